// File: rtl/sparse_accum.sv
// sparse_accum: serialises product bundles into a per-position partial-sum buffer,
// then drains nonzero sums as a sparse (value, position) stream at layer end.
module sparse_accum #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int LANES  = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   input  logic [5:0]                     in_count,
   input  logic [LANES-1:0][DATA_W-1:0]   in_data,
   input  logic [LANES-1:0][31:0]         in_pos,
   input  logic                           layer_done_in,
   input  logic [11:0]                    mapsize,
   output logic                           in_rdy,
   output logic                           out_valid,
   output logic [DATA_W-1:0]              out_data,
   output logic [31:0]                    out_pos,
   input  logic                           out_rdy,
   output logic                           layer_done_out,
   output logic                           err_oob
);
   localparam int LW = $clog2(LANES);
   localparam int CW = $clog2(LANES + 1);

   typedef enum logic [1:0] {IDLE, SERIAL, DRAIN, DONE} state_t;

   state_t                         state_q, state_d;
   logic [DATA_W-1:0]              mem_q [2**ADDR_W];
   logic [LANES-1:0][DATA_W-1:0]   cap_data_q;
   logic [LANES-1:0][31:0]         cap_pos_q;
   logic [CW-1:0]                  cnt_q, eff;
   logic [LW-1:0]                  lane_q, lane_d;
   logic [11:0]                    idx_q, idx_d;
   logic                           err_q, err_d;
   logic [31:0]                    lpos;
   logic [DATA_W-1:0]              cur, wr_data;
   logic [ADDR_W-1:0]              wr_addr;
   logic                           oob, last, adv, wr_en;

   // Single write port: lane accumulate in SERIAL, clear-on-accept in DRAIN.
   always_comb begin
      eff     = in_count > 6'(LANES) ? CW'(LANES) : CW'(in_count);
      lpos    = cap_pos_q[lane_q];
      oob     = lpos >= {20'd0, mapsize};
      last    = CW'(lane_q) == cnt_q - CW'(1);
      cur     = mem_q[idx_q[ADDR_W-1:0]];
      adv     = cur == '0 || out_rdy;
      wr_en   = (state_q == SERIAL && !oob) || (state_q == DRAIN && cur != '0 && out_rdy);
      wr_addr = state_q == SERIAL ? lpos[ADDR_W-1:0] : idx_q[ADDR_W-1:0];
      wr_data = state_q == SERIAL ? mem_q[wr_addr] + cap_data_q[lane_q] : '0;
      lane_d  = state_q == SERIAL ? lane_q + LW'(1) : '0;
      idx_d   = state_q == DRAIN ? (adv ? idx_q + 12'd1 : idx_q) : '0;
      err_d   = (state_q == SERIAL && oob) ? 1'b1 : (state_q == DONE && !layer_done_in) ? 1'b0 : err_q;
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) state_q <= IDLE;
      else state_q <= state_d;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = (in_valid && eff != '0) ? SERIAL :
                            layer_done_in ? (mapsize == 12'd0 ? DONE : DRAIN) : IDLE;
         SERIAL:  state_d = last ? IDLE : SERIAL;
         DRAIN:   state_d = (adv && idx_q == mapsize - 12'd1) ? DONE : DRAIN;
         default: state_d = layer_done_in ? DONE : IDLE;
      endcase
   end

   always_comb begin
      in_rdy         = state_q == IDLE && reset;
      out_valid      = state_q == DRAIN && cur != '0;
      out_data       = out_valid ? cur : '0;
      out_pos        = out_valid ? {20'd0, idx_q} : '0;
      layer_done_out = state_q == DONE;
      err_oob        = err_q;
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cap_data_q <= '0;
         cap_pos_q  <= '0;
         cnt_q      <= '0;
         lane_q     <= '0;
         idx_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         if (state_q == IDLE && in_valid) begin
            cap_data_q <= in_data;
            cap_pos_q  <= in_pos;
            cnt_q      <= eff;
         end
         lane_q <= lane_d;
         idx_q  <= idx_d;
         err_q  <= err_d;
      end

   always_ff @(posedge clk or negedge reset)
      if (!reset) for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= '0;
      else if (wr_en) mem_q[wr_addr] <= wr_data;
endmodule

// File: tb/tb_sparse_accum.sv
// tb_sparse_accum: directed bundles against an array model of the sum buffer,
// with a per-cycle compare of the drained stream against the model's expected pairs.
module tb_sparse_accum;
   logic             clk = 1'b0, reset = 1'b0, in_valid = 1'b0, layer_done_in = 1'b0, out_rdy = 1'b1;
   logic [5:0]       in_count = '0;
   logic [7:0][31:0] in_data = '0, in_pos = '0;
   logic [11:0]      mapsize = '0;
   logic             in_rdy, out_valid, layer_done_out, err_oob;
   logic [31:0]      out_data, out_pos;

   typedef struct packed {logic [31:0] v; logic [31:0] p;} pair_t;
   pair_t       exp_q[$], log_q[$];
   logic [31:0] model [1024];
   logic [31:0] bd [8], bp [8];
   int          checks = 0, fails = 0;

   always #5 clk = ~clk;

   sparse_accum dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_count(in_count), .in_data(in_data),
      .in_pos(in_pos), .layer_done_in(layer_done_in), .mapsize(mapsize), .in_rdy(in_rdy),
      .out_valid(out_valid), .out_data(out_data), .out_pos(out_pos), .out_rdy(out_rdy),
      .layer_done_out(layer_done_out), .err_oob(err_oob)
   );

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every presented pair must match the head of the model's expected stream.
   always @(negedge clk)
      if (reset && out_valid) begin
         if (exp_q.size() == 0) chk("spurious_emit", 64'(out_valid), 64'd0);
         else begin
            chk("emit", {out_data, out_pos}, exp_q[0]);
            if (out_rdy) begin
               log_q.push_back(exp_q[0]);
               void'(exp_q.pop_front());
            end
         end
      end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic clr_b();
      for (int i = 0; i < 8; i++) begin bd[i] = '0; bp[i] = '0; end
   endtask

   task automatic set_b(int i, logic [31:0] d, logic [31:0] p);
      bd[i] = d;
      bp[i] = p;
   endtask

   task automatic present(int cnt);
      int k = 0;
      while (!in_rdy && k < 100) begin @(posedge clk); #1; k++; end
      chk("bundle_rdy", 64'(in_rdy), 64'd1);
      in_valid = 1'b1;
      in_count = 6'(cnt);
      for (int i = 0; i < 8; i++) begin in_data[i] = bd[i]; in_pos[i] = bp[i]; end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic bundle(int cnt);
      int n = cnt > 8 ? 8 : cnt;
      present(cnt);
      for (int i = 0; i < n; i++)
         if (bp[i] < {20'd0, mapsize}) model[bp[i][9:0]] += bd[i];
      for (int c = 0; c < n; c++) begin
         chk("rdy_low", 64'(in_rdy), 64'd0);
         @(posedge clk); #1;
      end
      chk("rdy_back", 64'(in_rdy), 64'd1);
   endtask

   function automatic void prep();
      exp_q.delete();
      log_q.delete();
      for (int p = 0; p < int'(mapsize) && p < 1024; p++)
         if (model[p] != 0) begin
            exp_q.push_back({model[p], 32'(p)});
            model[p] = '0;
         end
   endfunction

   task automatic drain(int hold, int exp_cyc);
      int n = 0;
      prep();
      layer_done_in = 1'b1;
      out_rdy = hold == 0;
      @(posedge clk); #1;
      if (hold > 0) begin
         while (!out_valid && n < 3000) begin @(posedge clk); #1; n++; end
         for (int h = 0; h < hold; h++) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_pair", {out_data, out_pos}, exp_q.size() > 0 ? exp_q[0] : 64'd0);
            @(posedge clk); #1; n++;
         end
         out_rdy = 1'b1;
      end
      while (!layer_done_out && n < 3000) begin @(posedge clk); #1; n++; end
      chk("done_high", 64'(layer_done_out), 64'd1);
      if (exp_cyc >= 0) chk("drain_cycles", 64'(n), 64'(exp_cyc));
      chk("drain_left", 64'(exp_q.size()), 64'd0);
      layer_done_in = 1'b0;
      @(posedge clk); #1;
      chk("done_low", 64'(layer_done_out), 64'd0);
      chk("err_clear", 64'(err_oob), 64'd0);
      chk("idle_rdy", 64'(in_rdy), 64'd1);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) model[i] = '0;
      mapsize = 12'd4;
      #12;
      chk("rst_in_rdy", 64'(in_rdy), 64'd0);
      chk("rst_out", {31'd0, out_valid, out_data}, 64'd0);
      chk("rst_pos", 64'(out_pos), 64'd0);
      chk("rst_flags", {62'd0, layer_done_out, err_oob}, 64'd0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      chk("idle_rdy0", 64'(in_rdy), 64'd1);

      clr_b(); set_b(0, 5, 0); set_b(1, 7, 1); set_b(2, -32'sd2, 0);
      bundle(3);
      chk("model_b0", 64'(model[0]), 64'd3);
      chk("model_b1", 64'(model[1]), 64'd7);
      drain(0, -1);
      chk("t1_n", 64'(log_q.size()), 64'd2);
      chk("t1_first", log_q[0], {32'd3, 32'd0});
      chk("t1_second", log_q[1], {32'd7, 32'd1});
      drain(0, 4);

      mapsize = 12'd16;
      clr_b(); for (int i = 0; i < 8; i++) set_b(i, 1, 5);
      bundle(8);
      drain(0, -1);
      chk("full_n", 64'(log_q.size()), 64'd1);
      chk("full_pair", log_q[0], {32'd8, 32'd5});
      bundle(12);
      drain(0, -1);
      chk("clamp_pair", log_q[0], {32'd8, 32'd5});

      clr_b(); set_b(0, 9, 1); set_b(1, 4, 3);
      bundle(2);
      drain(5, -1);
      chk("bp_n", 64'(log_q.size()), 64'd2);
      chk("bp_first", log_q[0], {32'd9, 32'd1});

      clr_b(); set_b(0, 32'h7FFF_FFFF, 2); set_b(1, 1, 2); set_b(2, 4, 3); set_b(3, -32'sd4, 3);
      bundle(4);
      drain(0, -1);
      chk("wrap_n", 64'(log_q.size()), 64'd1);
      chk("wrap_pair", log_q[0], {32'h8000_0000, 32'd2});

      clr_b(); set_b(0, 11, 20); set_b(1, 2, 6); set_b(2, 3, 6);
      bundle(3);
      chk("oob_set", 64'(err_oob), 64'd1);
      clr_b();
      bundle(0);
      chk("oob_sticky", 64'(err_oob), 64'd1);
      drain(0, -1);
      chk("oob_n", 64'(log_q.size()), 64'd1);
      chk("oob_pair", log_q[0], {32'd5, 32'd6});

      mapsize = 12'd0;
      drain(0, 0);
      mapsize = 12'd16;

      clr_b(); for (int i = 0; i < 8; i++) set_b(i, i + 1, i);
      present(8);
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      chk("rs_in_rdy", 64'(in_rdy), 64'd0);
      chk("rs_out", {31'd0, out_valid, out_data}, 64'd0);
      chk("rs_flags", {62'd0, layer_done_out, err_oob}, 64'd0);
      @(negedge clk) reset = 1'b1;

      clr_b(); set_b(0, 1, 4);
      bundle(1);
      prep();
      layer_done_in = 1'b1;
      out_rdy = 1'b0;
      for (int k = 0; k < 100 && !out_valid; k++) begin @(posedge clk); #1; end
      chk("rd_valid", 64'(out_valid), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("rd_out", {31'd0, out_valid, out_data}, 64'd0);
      chk("rd_pos", 64'(out_pos), 64'd0);
      chk("rd_flags", {62'd0, layer_done_out, in_rdy}, 64'd0);
      exp_q.delete();
      layer_done_in = 1'b0;
      out_rdy = 1'b1;
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      drain(0, 16);
      chk("post_reset_n", 64'(log_q.size()), 64'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
